// File: rtl/host_bridge_pkg.sv
// host_bridge_pkg: shared state encoding and default widths for the host
// memory bridge.
package host_bridge_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        KICK,
        RUN,
        DUMP_RD,
        DUMP_CAP,
        DUMP_OUT,
        FIN
    } state_t;

    // States in which the bridge, not the core, masters the data-memory port.
    function automatic logic owns_mem(state_t s);
        return (s == LOAD) || (s == DUMP_RD) || (s == DUMP_CAP) || (s == DUMP_OUT);
    endfunction

endpackage

// File: rtl/host_addr_gen.sv
// host_addr_gen: word index counter plus base offset. Both the index and the
// resulting address wrap modulo 2^ADDR_W.
module host_addr_gen #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              clr,
    input  logic              inc,
    input  logic [ADDR_W-1:0] base,
    output logic [ADDR_W-1:0] idx,
    output logic [ADDR_W-1:0] addr
);

    // Index counter: clear wins over increment.
    always_ff @(posedge clk) begin
        if (RESET || clr) idx <= '0;
        else if (inc)     idx <= idx + ADDR_W'(1);
    end

    assign addr = base + idx;

endmodule

// File: rtl/host_mem_bridge.sv
// host_mem_bridge: loads host words into data memory, kicks the core, waits
// for END, then streams the result region back to the host.
// Optional: define HOST_CHECKSUM_EN to add the dump_sum output.
module host_mem_bridge
    import host_bridge_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int LOAD_BASE  = 0,
    parameter int LOAD_WORDS = 32,
    parameter int DUMP_BASE  = 32,
    parameter int DUMP_WORDS = 16
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              cmd_go,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              dump_valid,
    output logic [DATA_W-1:0] dump_data,
    input  logic              dump_ready,
    output logic              core_start,
    input  logic              core_end,
    output logic              mem_own,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done
`ifdef HOST_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] dump_sum
`endif
);

    localparam logic [ADDR_W-1:0] LOAD_BASE_A = ADDR_W'(LOAD_BASE);
    localparam logic [ADDR_W-1:0] DUMP_BASE_A = ADDR_W'(DUMP_BASE);
    localparam logic [ADDR_W-1:0] LOAD_LAST   = ADDR_W'(LOAD_WORDS - 1);
    localparam logic [ADDR_W-1:0] DUMP_LAST   = ADDR_W'(DUMP_WORDS - 1);

    state_t            state, state_nxt;
    logic              idx_clr, idx_inc;
    logic [ADDR_W-1:0] idx, addr, addr_base;
    logic              done_q;
    logic [DATA_W-1:0] dump_q;

    // One shared index serves both phases; only the base changes.
    assign addr_base = (state == LOAD) ? LOAD_BASE_A : DUMP_BASE_A;

    host_addr_gen #(.ADDR_W(ADDR_W)) u_addr (
        .clk   (clk),
        .RESET (RESET),
        .clr   (idx_clr),
        .inc   (idx_inc),
        .base  (addr_base),
        .idx   (idx),
        .addr  (addr)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and memory/handshake strobes; the address bus is only driven
    // while a strobe is high so an idle port reads as all zeros.
    always_comb begin
        state_nxt   = state;
        idx_clr     = 1'b0;
        idx_inc     = 1'b0;
        load_ready  = 1'b0;
        mem_write   = 1'b0;
        mem_read    = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        core_start  = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_go) begin
                    state_nxt = LOAD;
                    idx_clr   = 1'b1;
                end
            end
            LOAD: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    mem_write   = 1'b1;
                    mem_address = addr;
                    mem_wdata   = load_data;
                    if (idx == LOAD_LAST) begin
                        state_nxt = KICK;
                        idx_clr   = 1'b1;
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
            end
            KICK: begin
                // Unconditional hop to RUN: core_end is not looked at here.
                core_start = 1'b1;
                state_nxt  = RUN;
            end
            RUN: begin
                if (core_end) state_nxt = DUMP_RD;
            end
            DUMP_RD: begin
                mem_read    = 1'b1;
                mem_address = addr;
                state_nxt   = DUMP_CAP;
            end
            DUMP_CAP: state_nxt = DUMP_OUT;
            DUMP_OUT: begin
                if (dump_ready) begin
                    if (idx == DUMP_LAST) begin
                        state_nxt = FIN;
                        idx_clr   = 1'b1;
                    end else begin
                        state_nxt = DUMP_RD;
                        idx_inc   = 1'b1;
                    end
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Completion flag and captured read word.
    always_ff @(posedge clk) begin
        if (RESET) begin
            done_q <= 1'b0;
            dump_q <= '0;
        end else begin
            if (state == IDLE && cmd_go) done_q <= 1'b0;
            else if (state_nxt == FIN)   done_q <= 1'b1;
            if (state == DUMP_CAP) dump_q <= mem_rdata;
        end
    end

    assign mem_own    = owns_mem(state);
    assign busy       = (state != IDLE) && (state != FIN);
    assign done       = done_q;
    assign dump_valid = (state == DUMP_OUT);
    assign dump_data  = dump_q;

`ifdef HOST_CHECKSUM_EN
    // Running sum of the words the host has accepted in this dump.
    always_ff @(posedge clk) begin
        if (RESET || (state == IDLE && cmd_go)) dump_sum <= '0;
        else if (state == DUMP_OUT && dump_ready) dump_sum <= dump_sum + dump_q;
    end
`endif

endmodule

// File: tb/tb_host_mem_bridge.sv
// tb_host_mem_bridge: directed scoreboard bench for host_mem_bridge with a
// small data-memory model (1-cycle read latency).
module tb_host_mem_bridge;

    logic        clk;
    logic        RESET;
    logic        cmd_go;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_ready;
    logic        dump_valid;
    logic [15:0] dump_data;
    logic        dump_ready;
    logic        core_start;
    logic        core_end;
    logic        mem_own;
    logic        mem_write;
    logic        mem_read;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        busy;
    logic        done;
`ifdef HOST_CHECKSUM_EN
    logic [15:0] dump_sum;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t         exp_wr[$];
    logic [15:0] exp_rd[$];
    logic [15:0] exp_dump[$];

    logic        pre_we;
    logic [5:0]  pre_addr;
    logic [15:0] pre_data;
    logic [15:0] mem [0:63];
    logic [15:0] hold;

    host_mem_bridge #(
        .DATA_W(16), .ADDR_W(16), .LOAD_BASE(0), .LOAD_WORDS(4),
        .DUMP_BASE(32), .DUMP_WORDS(2)
    ) dut (
        .clk(clk), .RESET(RESET), .cmd_go(cmd_go),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .dump_valid(dump_valid), .dump_data(dump_data), .dump_ready(dump_ready),
        .core_start(core_start), .core_end(core_end), .mem_own(mem_own),
        .mem_write(mem_write), .mem_read(mem_read), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .done(done)
`ifdef HOST_CHECKSUM_EN
        , .dump_sum(dump_sum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: bench preload port plus the bridge's port.
    always @(posedge clk) begin
        if (pre_we)    mem[pre_addr] <= pre_data;
        if (mem_write) mem[mem_address[5:0]] <= mem_wdata;
        if (mem_read)  mem_rdata <= mem[mem_address[5:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [5:0] a, input logic [15:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        exp_rd.push_back(16'(32 + exp_rd.size()));
        exp_dump.push_back(d);
        tick();
        pre_we = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_done"},  32'(done), 0);
        chk({tag, "_own"},   32'(mem_own), 0);
        chk({tag, "_wr"},    32'(mem_write), 0);
        chk({tag, "_rd"},    32'(mem_read), 0);
        chk({tag, "_addr"},  32'(mem_address), 0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 0);
        chk({tag, "_dvld"},  32'(dump_valid), 0);
        chk({tag, "_ddata"}, 32'(dump_data), 0);
        chk({tag, "_start"}, 32'(core_start), 0);
        chk({tag, "_lrdy"},  32'(load_ready), 0);
`ifdef HOST_CHECKSUM_EN
        chk({tag, "_sum"},   32'(dump_sum), 0);
`endif
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 40 && done !== 1'b1; i++) @(negedge clk);
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_own"},  32'(mem_own), 0);
        chk({tag, "_dump_left"}, 32'(exp_dump.size()), 0);
        chk({tag, "_rd_left"},   32'(exp_rd.size()), 0);
    endtask

    // Scoreboard monitor: every memory access and dump handshake is popped
    // against what the stimulus queued.
    always @(negedge clk) begin
        wr_t         e;
        logic [15:0] r;
        if (mem_write) begin
            chk("wr_own", 32'(mem_own), 1);
            chk("wr_rd_excl", 32'(mem_read), 0);
            if (exp_wr.size() == 0) chk("wr_extra", 32'(mem_write), 0);
            else begin
                e = exp_wr.pop_front();
                chk("wr_addr", 32'(mem_address), 32'(e.addr));
                chk("wr_data", 32'(mem_wdata), 32'(e.data));
            end
        end
        if (mem_read) begin
            chk("rd_own", 32'(mem_own), 1);
            if (exp_rd.size() == 0) chk("rd_extra", 32'(mem_read), 0);
            else begin
                r = exp_rd.pop_front();
                chk("rd_addr", 32'(mem_address), 32'(r));
            end
        end
        if (dump_valid && dump_ready) begin
            if (exp_dump.size() == 0) chk("dump_extra", 32'(dump_valid), 0);
            else begin
                r = exp_dump.pop_front();
                chk("dump_data", 32'(dump_data), 32'(r));
            end
        end
    end

    initial begin
        RESET = 1'b1; cmd_go = 1'b0; load_valid = 1'b0; load_data = '0;
        dump_ready = 1'b0; core_end = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        repeat (3) tick();
        RESET = 1'b0;
        @(negedge clk);
        chk_zero("reset");
        tick();

        // Job 1: streaming load, plain dump of 0x00AA, 0x00BB.
        preload(6'd32, 16'h00AA);
        preload(6'd33, 16'h00BB);
        cmd_go = 1'b1;
        tick();
        cmd_go = 1'b0;
        @(negedge clk);
        chk("j1_busy", 32'(busy), 1);
        chk("j1_own", 32'(mem_own), 1);
        chk("j1_lrdy", 32'(load_ready), 1);
        chk("j1_nowr_idle", 32'(mem_write), 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1;
            load_data  = 16'(i + 1);
            exp_wr.push_back('{addr: 16'(i), data: 16'(i + 1)});
            tick();
        end
        load_valid = 1'b0;
        @(negedge clk);
        chk("j1_kick_start", 32'(core_start), 1);
        chk("j1_kick_own", 32'(mem_own), 0);
        chk("j1_wr_left", 32'(exp_wr.size()), 0);
        tick();
        @(negedge clk);
        chk("j1_start_once", 32'(core_start), 0);
        chk("j1_run_own", 32'(mem_own), 0);
        chk("j1_run_busy", 32'(busy), 1);
        dump_ready = 1'b1;
        repeat (4) tick();
        core_end = 1'b1;
        tick();
        core_end = 1'b0;
        @(negedge clk);
        chk("j1_dump_own", 32'(mem_own), 1);
        wait_done("j1");
`ifdef HOST_CHECKSUM_EN
        chk("j1_sum", 32'(dump_sum), 32'h0165);
`endif

        // Job 2: toggling load_valid, END during KICK, cmd_go during RUN,
        // host backpressure on the first dump word.
        dump_ready = 1'b0;
        preload(6'd32, 16'hFFFF);
        preload(6'd33, 16'h0002);
        chk("j2_done_held", 32'(done), 1);
        cmd_go = 1'b1;
        tick();
        cmd_go = 1'b0;
        @(negedge clk);
        chk("j2_done_clr", 32'(done), 0);
`ifdef HOST_CHECKSUM_EN
        chk("j2_sum_clr", 32'(dump_sum), 0);
`endif
        tick();
        for (int k = 0; k < 7; k++) begin
            load_valid = (k % 2 == 0);
            load_data  = (k % 2 == 0) ? 16'(16'h11 * (k / 2 + 1)) : 16'hDEAD;
            if (k % 2 == 0) exp_wr.push_back('{addr: 16'(k / 2), data: 16'(16'h11 * (k / 2 + 1))});
            @(negedge clk);
            if (k % 2 != 0) chk("j2_nowr_gap", 32'(mem_write), 0);
            tick();
        end
        load_valid = 1'b0;
        core_end   = 1'b1;
        @(negedge clk);
        chk("j2_kick_start", 32'(core_start), 1);
        chk("j2_wr_left", 32'(exp_wr.size()), 0);
        tick();
        core_end = 1'b0;
        cmd_go   = 1'b1;
        tick();
        cmd_go = 1'b0;
        @(negedge clk);
        chk("j2_run_busy", 32'(busy), 1);
        chk("j2_run_own", 32'(mem_own), 0);
        chk("j2_run_lrdy", 32'(load_ready), 0);
        chk("j2_run_rd", 32'(mem_read), 0);
        tick();
        core_end = 1'b1;
        tick();
        core_end = 1'b0;
        for (int i = 0; i < 10 && dump_valid !== 1'b1; i++) @(negedge clk);
        chk("j2_bp_valid", 32'(dump_valid), 1);
        hold = dump_data;
        chk("j2_bp_first", 32'(hold), 32'hFFFF);
        repeat (4) begin
            @(negedge clk);
            chk("j2_bp_vld_hold", 32'(dump_valid), 1);
            chk("j2_bp_data_hold", 32'(dump_data), 32'(hold));
            chk("j2_bp_no_rd", 32'(mem_read), 0);
        end
        tick();
        dump_ready = 1'b1;
        wait_done("j2");
`ifdef HOST_CHECKSUM_EN
        chk("j2_sum_wrap", 32'(dump_sum), 32'h0001);
`endif

        // Job 3: reset in the middle of LOAD, then restart from LOAD_BASE.
        tick();
        cmd_go = 1'b1;
        tick();
        cmd_go = 1'b0;
        for (int i = 0; i < 2; i++) begin
            load_valid = 1'b1;
            load_data  = 16'(16'h30 + i);
            exp_wr.push_back('{addr: 16'(i), data: 16'(16'h30 + i)});
            tick();
        end
        load_valid = 1'b0;
        RESET = 1'b1;
        tick();
        @(negedge clk);
        chk_zero("midrst");
        tick();
        RESET  = 1'b0;
        cmd_go = 1'b1;
        tick();
        cmd_go     = 1'b0;
        load_valid = 1'b1;
        load_data  = 16'h0055;
        exp_wr.push_back('{addr: 16'h0000, data: 16'h0055});
        tick();
        load_valid = 1'b0;
        @(negedge clk);
        chk("j3_wr_left", 32'(exp_wr.size()), 0);
        chk("j3_busy", 32'(busy), 1);
        chk("j3_done", 32'(done), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
